// File: rtl/ncl_pkg.sv
// Shared types for the NCL word receiver.
// FSM states, rail indices and the dual-rail pair type.
package ncl_pkg;

  typedef enum logic {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } ncl_state_e;

  localparam int RAIL_T = 1;
  localparam int RAIL_F = 0;

  typedef logic [1:0] dr_pair_t;

endpackage

// File: rtl/ncl_rail_sync.sv
// Async-reset flop chain bringing one NCL rail
// into the clk domain.
module ncl_rail_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic init_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // shift the rail one flop deeper each cycle
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d_i};
  end

  // synchronizer flops, cleared by reset
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) chain_q <= '0;
    else         chain_q <= chain_d;
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/ncl_word_receiver.sv
// Clocked sink/checker for a dual-rail NCL word stream:
// completion detection, capture, count, sequence check.
module ncl_word_receiver
  import ncl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CHECK_SEQ   = 1
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic [WIDTH-1:0] sum_t_i,
  input  logic [WIDTH-1:0] sum_f_i,
  input  logic             cout_t_i,
  input  logic             cout_f_i,
  output logic             comp_o,
  output logic [WIDTH-1:0] data_o,
  output logic             cout_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [31:0]      word_cnt_o,
  output logic             enc_err_o,
  output logic             seq_err_o
);

  localparam int NB = WIDTH + 1;

  logic [NB-1:0] t_raw;
  logic [NB-1:0] f_raw;
  logic [NB-1:0] t_s;
  logic [NB-1:0] f_s;
  dr_pair_t      pair [NB];

  assign t_raw = {cout_t_i, sum_t_i};
  assign f_raw = {cout_f_i, sum_f_i};

  for (genvar i = 0; i < NB; i++) begin : g_bit
    ncl_rail_sync #(.STAGES(SYNC_STAGES)) u_sync_t (
      .clk    (clk),
      .init_n (init_n),
      .d_i    (t_raw[i]),
      .q_o    (t_s[i])
    );
    ncl_rail_sync #(.STAGES(SYNC_STAGES)) u_sync_f (
      .clk    (clk),
      .init_n (init_n),
      .d_i    (f_raw[i]),
      .q_o    (f_s[i])
    );
  end

  logic [NB-1:0] bit_cmp;
  logic [NB-1:0] bit_ill;
  logic          word_cmp;
  logic          word_nul;
  logic          any_ill;

  // per-bit status and word-level reduction trees
  always_comb begin
    bit_cmp = '0;
    bit_ill = '0;
    for (int i = 0; i < NB; i++) begin
      pair[i]         = '0;
      pair[i][RAIL_T] = t_s[i];
      pair[i][RAIL_F] = f_s[i];
      bit_cmp[i]      = pair[i][RAIL_T] | pair[i][RAIL_F];
      bit_ill[i]      = pair[i][RAIL_T] & pair[i][RAIL_F];
    end
    word_cmp = &bit_cmp;
    word_nul = ~|bit_cmp;
    any_ill  = |bit_ill;
  end

  ncl_state_e       state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             cout_q, cout_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             enc_q, enc_d;
  logic             seq_q, seq_d;
  logic             seeded_q, seeded_d;

  logic             free;
  logic             capture;
  logic [WIDTH-1:0] cap_word;
  logic             cap_cout;
  logic [WIDTH-1:0] prev_inc;
  logic             seq_bad;

  // FSM, output register, counter and checker
  always_comb begin
    free     = !valid_q | ready_i;
    capture  = (state_q == WAIT_DATA) & word_cmp & free;
    cap_word = t_s[WIDTH-1:0];
    cap_cout = t_s[WIDTH];
    prev_inc = data_q + WIDTH'(1);
    seq_bad  = seeded_q
             & ((cap_word != prev_inc)
             | (cap_cout != (cap_word == '0)));

    state_d  = state_q;
    valid_d  = valid_q;
    data_d   = data_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    enc_d    = enc_q | any_ill;
    seq_d    = seq_q;
    seeded_d = seeded_q;

    unique case (state_q)
      WAIT_DATA: if (capture) state_d = WAIT_NULL;
      WAIT_NULL: if (word_nul) state_d = WAIT_DATA;
      default:   state_d = WAIT_DATA;
    endcase

    if (valid_q && ready_i) valid_d = 1'b0;

    if (capture) begin
      valid_d  = 1'b1;
      data_d   = cap_word;
      cout_d   = cap_cout;
      cnt_d    = cnt_q + 32'd1;
      seeded_d = 1'b1;
      if (CHECK_SEQ != 0 && seq_bad) seq_d = 1'b1;
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q  <= WAIT_DATA;
      valid_q  <= 1'b0;
      data_q   <= '0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
      enc_q    <= 1'b0;
      seq_q    <= 1'b0;
      seeded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
      enc_q    <= enc_d;
      seq_q    <= seq_d;
      seeded_q <= seeded_d;
    end
  end

  assign comp_o     = (state_q == WAIT_NULL);
  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign cout_o     = cout_q;
  assign word_cnt_o = cnt_q;
  assign enc_err_o  = enc_q;
  assign seq_err_o  = seq_q;

endmodule

// File: tb/tb_ncl_word_receiver.sv
// Randomized bench for ncl_word_receiver against a
// word-level behavioural model of the receiver.
module tb_ncl_word_receiver;

  logic        clk = 1'b0;
  logic        init_n;
  logic [31:0] sum_t, sum_f;
  logic        cout_t, cout_f;
  logic        comp;
  logic [31:0] data;
  logic        cout;
  logic        valid;
  logic        ready;
  logic [31:0] cnt;
  logic        enc_err;
  logic        seq_err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_cnt;
  logic        m_enc;
  logic        m_seq;
  logic        m_seeded;
  logic [31:0] m_prev;

  always #5 clk = ~clk;

  ncl_word_receiver dut (
    .clk        (clk),
    .init_n     (init_n),
    .sum_t_i    (sum_t),
    .sum_f_i    (sum_f),
    .cout_t_i   (cout_t),
    .cout_f_i   (cout_f),
    .comp_o     (comp),
    .data_o     (data),
    .cout_o     (cout),
    .valid_o    (valid),
    .ready_i    (ready),
    .word_cnt_o (cnt),
    .enc_err_o  (enc_err),
    .seq_err_o  (seq_err)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_null();
    sum_t  = '0;
    sum_f  = '0;
    cout_t = 1'b0;
    cout_f = 1'b0;
  endtask

  task automatic drive_data(input logic [31:0] w,
                            input logic co,
                            input int ill);
    sum_t  = w;
    sum_f  = ~w;
    cout_t = co;
    cout_f = ~co;
    if (ill >= 0) begin
      sum_t[ill] = 1'b1;
      sum_f[ill] = 1'b1;
    end
  endtask

  // model: a word is accepted; update count and checker
  task automatic model_capture(input logic [31:0] w,
                               input logic co);
    if (m_seeded &&
        (w != m_prev + 32'd1 || co != (w == 32'd0)))
      m_seq = 1'b1;
    m_seeded = 1'b1;
    m_prev   = w;
    m_cnt    = m_cnt + 32'd1;
  endtask

  task automatic do_reset();
    init_n = 1'b0;
    drive_null();
    #1;
    check("rst_comp", comp, 0);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_cout", cout, 0);
    check("rst_cnt", cnt, 0);
    check("rst_enc", enc_err, 0);
    check("rst_seq", seq_err, 0);
    tick();
    init_n   = 1'b1;
    ready    = 1'b1;
    m_cnt    = '0;
    m_enc    = 1'b0;
    m_seq    = 1'b0;
    m_seeded = 1'b0;
    m_prev   = '0;
    tick();
  endtask

  task automatic wait_comp(input logic exp,
                           input bit rnd_ready);
    int n;
    for (n = 0; n < 200; n++) begin
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
      tick();
      if (comp == exp) break;
    end
    check(exp ? "wait_comp_hi" : "wait_comp_lo",
          comp, exp);
  endtask

  task automatic send_word(input logic [31:0] w,
                           input logic co,
                           input int ill,
                           input bit rnd_ready);
    logic [31:0] got_w;
    got_w = w;
    if (ill >= 0) begin
      got_w[ill] = 1'b1;
      m_enc = 1'b1;
    end
    drive_data(w, co, ill);
    wait_comp(1'b1, rnd_ready);
    model_capture(got_w, co);
    check("cap_data", data, got_w);
    check("cap_cout", cout, co);
    check("cap_valid", valid, 1);
    check("cap_cnt", cnt, m_cnt);
    check("cap_seq", seq_err, m_seq);
    check("cap_enc", enc_err, m_enc);
    drive_null();
    wait_comp(1'b0, rnd_ready);
  endtask

  initial begin
    logic [31:0] w;
    logic        co;
    int          ill;
    ready = 1'b1;
    do_reset();

    // exact latency for a single word
    drive_data(32'h5, 1'b0, -1);
    tick();
    tick();
    check("lat_comp_early", comp, 0);
    check("lat_valid_early", valid, 0);
    tick();
    check("lat_comp", comp, 1);
    check("lat_valid", valid, 1);
    check("lat_data", data, 32'h5);
    tick();
    check("lat_consumed", valid, 0);
    drive_null();
    tick();
    tick();
    check("null_comp_early", comp, 1);
    tick();
    check("null_comp", comp, 0);
    check("lat_cnt", cnt, 1);

    // wrap-around sequence stays clean
    do_reset();
    send_word(32'hFFFF_FFFE, 1'b0, -1, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0, -1, 1'b0);
    send_word(32'h0000_0000, 1'b1, -1, 1'b0);
    check("wrap_seq", seq_err, 0);
    check("wrap_cnt", cnt, 3);

    // skipped value
    do_reset();
    send_word(32'd7, 1'b0, -1, 1'b0);
    send_word(32'd9, 1'b0, -1, 1'b0);
    check("skip_seq", seq_err, 1);

    // zero without carry
    do_reset();
    send_word(32'hFFFF_FFFF, 1'b0, -1, 1'b0);
    send_word(32'h0, 1'b0, -1, 1'b0);
    check("nocarry_seq", seq_err, 1);

    // backpressure holds the ring
    do_reset();
    ready = 1'b0;
    send_word(32'h100, 1'b0, -1, 1'b0);
    drive_data(32'h101, 1'b0, -1);
    repeat (10) tick();
    check("bp_comp", comp, 0);
    check("bp_data", data, 32'h100);
    check("bp_valid", valid, 1);
    check("bp_cnt", cnt, 1);
    ready = 1'b1;
    tick();
    check("bp_rel_comp", comp, 1);
    check("bp_rel_data", data, 32'h101);
    check("bp_rel_valid", valid, 1);
    check("bp_rel_cnt", cnt, 2);
    tick();
    check("bp_drain", valid, 0);
    drive_null();
    wait_comp(1'b0, 1'b0);

    // illegal bit and partial wavefront
    do_reset();
    send_word(32'h10, 1'b0, 3, 1'b0);
    check("ill_bit3", data[3], 1);
    w = 32'h0000_A5C3;
    sum_t  = w & 32'h0000_FFFF;
    sum_f  = ~w & 32'h0000_FFFF;
    cout_t = 1'b0;
    cout_f = 1'b0;
    repeat (10) tick();
    check("part_comp", comp, 0);
    check("part_cnt", cnt, 1);
    drive_null();
    repeat (5) tick();

    // reset while holding a word in WAIT_NULL
    do_reset();
    ready = 1'b0;
    drive_data(32'h33, 1'b0, -1);
    wait_comp(1'b1, 1'b0);
    check("mid_valid", valid, 1);
    do_reset();
    send_word(32'h44, 1'b0, -1, 1'b0);
    check("post_rst_cnt", cnt, 1);
    check("post_rst_seq", seq_err, 0);

    // randomized stream with random ready
    do_reset();
    w = $urandom;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) < 7) w = w + 32'd1;
      else w = $urandom;
      co = (w == 32'd0);
      if ($urandom_range(0, 19) == 0) co = ~co;
      ill = -1;
      if ($urandom_range(0, 14) == 0)
        ill = int'($urandom_range(0, 31));
      send_word(w, co, ill, 1'b1);
      if (ill >= 0) w[ill] = 1'b1;
    end
    check("rnd_cnt", cnt, m_cnt);
    check("rnd_seq", seq_err, m_seq);
    check("rnd_enc", enc_err, m_enc);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
